// File: rtl/muldiv_unit.sv
// Radix-2 iterative RV32M multiply/divide unit with valid/ready handshake and kill.
// Optional MULDIV_FAST_SPECIAL_EN: divide-by-zero, signed overflow and zero multiplies finish in one cycle.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [OP_WIDTH-1:0]   iOp,
  input  logic [DATA_WIDTH-1:0] iSrcA,
  input  logic [DATA_WIDTH-1:0] iSrcB,
  input  logic                  iKill,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [DATA_WIDTH-1:0] oResult,
  output logic                  oZero
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ZERO    = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONES    = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [2:0]              op_r;
  logic [DATA_WIDTH-1:0]   src_a_r, src_b_r;
  logic [DATA_WIDTH-1:0]   addend_r, hi_r, lo_r;
  logic [CW-1:0]           cnt_r;
  logic                    prep_r, neg_r, rneg_r;
  logic [DATA_WIDTH-1:0]   result_r;

  logic                    a_neg_s, b_neg_s;
  logic [DATA_WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [DATA_WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
  logic [DATA_WIDTH-1:0]   hi_n_s, lo_n_s, final_s;
  logic [2*DATA_WIDTH-1:0] prod_s;

  // Operations whose result is known without iterating.
  function automatic logic is_special(input logic [2:0] op,
                                      input logic [DATA_WIDTH-1:0] a,
                                      input logic [DATA_WIDTH-1:0] b);
    if (op[2]) begin
      return (b == ZERO) || (!op[0] && (a == MIN_NEG) && (b == ONES));
    end else begin
      return (a == ZERO) || (b == ZERO);
    end
  endfunction

  function automatic logic [DATA_WIDTH-1:0] special_result(input logic [2:0] op,
                                                           input logic [DATA_WIDTH-1:0] a,
                                                           input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] r;
    r = ZERO;
    if (op[2]) begin
      if (b == ZERO) begin
        r = op[1] ? a : ONES;
      end else begin
        r = op[1] ? ZERO : a;
      end
    end else begin
      r = ZERO;
    end
    return r;
  endfunction

  // Operand signedness and magnitudes, consumed by the preparation cycle.
  always_comb begin
    a_neg_s = (op_r[2] ? ~op_r[0] : ~(op_r[1] & op_r[0])) & src_a_r[DATA_WIDTH-1];
    b_neg_s = (op_r[2] ? ~op_r[0] : ~op_r[1]) & src_b_r[DATA_WIDTH-1];
    a_mag_s = a_neg_s ? (ZERO - src_a_r) : src_a_r;
    b_mag_s = b_neg_s ? (ZERO - src_b_r) : src_b_r;
  end

  // One shift/add (multiply) or restoring shift/subtract (divide) step, plus final correction.
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + ({(DATA_WIDTH+1){lo_r[0]}} & {1'b0, addend_r});
    div_shift_s = {hi_r, lo_r[DATA_WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, addend_r};
    if (op_r[2]) begin
      hi_n_s = div_diff_s[DATA_WIDTH] ? div_shift_s[DATA_WIDTH-1:0] : div_diff_s[DATA_WIDTH-1:0];
      lo_n_s = {lo_r[DATA_WIDTH-2:0], ~div_diff_s[DATA_WIDTH]};
    end else begin
      hi_n_s = mul_sum_s[DATA_WIDTH:1];
      lo_n_s = {mul_sum_s[0], lo_r[DATA_WIDTH-1:1]};
    end
    prod_s = neg_r ? ({(2*DATA_WIDTH){1'b0}} - {hi_n_s, lo_n_s}) : {hi_n_s, lo_n_s};
    case (op_r)
      3'b000:                 final_s = prod_s[DATA_WIDTH-1:0];
      3'b001, 3'b010, 3'b011: final_s = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
      3'b100, 3'b101:         final_s = neg_r ? (ZERO - lo_n_s) : lo_n_s;
      3'b110, 3'b111:         final_s = rneg_r ? (ZERO - hi_n_s) : hi_n_s;
      default:                final_s = ZERO;
    endcase
    // The magnitude datapath would sign-correct the all-ones quotient; force the defined value.
    if (op_r[2] && (src_b_r == ZERO)) begin
      final_s = special_result(op_r, src_a_r, src_b_r);
    end else begin
      final_s = final_s;
    end
  end

  // State register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic; kill overrides every other input.
  always_comb begin
    state_s = state_r;
    if (iKill) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (iValid) begin
`ifdef MULDIV_FAST_SPECIAL_EN
            state_s = is_special(iOp[2:0], iSrcA, iSrcB) ? DONE : CALC;
`else
            state_s = CALC;
`endif
          end else begin
            state_s = IDLE;
          end
        end
        CALC:    state_s = (!prep_r && (cnt_r == CNT_ONE)) ? DONE : CALC;
        DONE:    state_s = iReady ? IDLE : DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Datapath: operand capture, magnitude preparation, iterations and result latch.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      op_r     <= 3'b000;
      src_a_r  <= ZERO;
      src_b_r  <= ZERO;
      addend_r <= ZERO;
      hi_r     <= ZERO;
      lo_r     <= ZERO;
      cnt_r    <= CNT_ZERO;
      prep_r   <= 1'b0;
      neg_r    <= 1'b0;
      rneg_r   <= 1'b0;
      result_r <= ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (iValid && !iKill) begin
            op_r    <= iOp[2:0];
            src_a_r <= iSrcA;
            src_b_r <= iSrcB;
            cnt_r   <= CNT_LOAD;
            prep_r  <= 1'b1;
`ifdef MULDIV_FAST_SPECIAL_EN
            if (is_special(iOp[2:0], iSrcA, iSrcB)) begin
              result_r <= special_result(iOp[2:0], iSrcA, iSrcB);
              cnt_r    <= CNT_ZERO;
              prep_r   <= 1'b0;
            end
`endif
          end
        end
        CALC: begin
          if (iKill) begin
            cnt_r  <= CNT_ZERO;
            prep_r <= 1'b0;
          end else if (prep_r) begin
            addend_r <= op_r[2] ? b_mag_s : a_mag_s;
            lo_r     <= op_r[2] ? a_mag_s : b_mag_s;
            hi_r     <= ZERO;
            neg_r    <= a_neg_s ^ b_neg_s;
            rneg_r   <= a_neg_s;
            prep_r   <= 1'b0;
          end else begin
            hi_r  <= hi_n_s;
            lo_r  <= lo_n_s;
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) result_r <= final_s;
          end
        end
        DONE:    cnt_r <= CNT_ZERO;
        default: cnt_r <= CNT_ZERO;
      endcase
    end
  end

  assign oReady  = (state_r == IDLE);
  assign oValid  = (state_r == DONE);
  assign oResult = result_r;
  assign oZero   = (result_r == ZERO);

endmodule
